// File: rtl/alu_exec_unit.sv
// Sequential ALU execute stage: 1-cycle logic/arith/LUI, iterative 1-bit-per-cycle SLL/SRL.
// Define ALU_OVERFLOW_EN to build signed-overflow detection for ADD/SUB.
module alu_exec_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             ALUOperation,
    input  logic [DATA_WIDTH-1:0]  A,
    input  logic [DATA_WIDTH-1:0]  B,
    input  logic [SHAMT_WIDTH-1:0] shamt,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  ALUResult,
    output logic                   Zero,
    output logic                   Illegal,
    output logic                   Overflow
);
    localparam int HALF = DATA_WIDTH / 2;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_NOR = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_SLL = 4'b0101;
    localparam logic [3:0] OP_SRL = 4'b0110;
    localparam logic [3:0] OP_LUI = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                   state_reg, state_next;
    logic [DATA_WIDTH-1:0]    shift_reg, shift_next;
    logic [SHAMT_WIDTH-1:0]   count_reg, count_next;
    logic                     dir_left_reg, dir_left_next;
    logic [DATA_WIDTH-1:0]    result_reg, result_next;
    logic                     zero_reg, zero_next;
    logic                     illegal_reg, illegal_next;

    logic [DATA_WIDTH-1:0]    alu_value;
    logic                     alu_illegal;
    logic                     alu_is_shift;
    logic [DATA_WIDTH-1:0]    shift_step;
    logic                     accept;

    assign in_ready  = (state_reg == ST_IDLE);
    assign out_valid = (state_reg == ST_DONE);
    assign accept    = in_valid && in_ready;

    // Single-cycle result; for shifts this is B itself, which is the shamt==0 answer.
    always_comb begin
        alu_value    = '0;
        alu_illegal  = 1'b0;
        alu_is_shift = 1'b0;
        case (ALUOperation)
            OP_AND: alu_value = A & B;
            OP_OR:  alu_value = A | B;
            OP_NOR: alu_value = ~(A | B);
            OP_ADD: alu_value = A + B;
            OP_SUB: alu_value = A - B;
            OP_SLL: begin
                alu_value    = B;
                alu_is_shift = 1'b1;
            end
            OP_SRL: begin
                alu_value    = B;
                alu_is_shift = 1'b1;
            end
            OP_LUI: alu_value = {B[HALF-1:0], {HALF{1'b0}}};
            default: alu_illegal = 1'b1;
        endcase
    end

    assign shift_step = dir_left_reg ? (shift_reg << 1) : (shift_reg >> 1);

    always_comb begin
        state_next    = state_reg;
        shift_next    = shift_reg;
        count_next    = count_reg;
        dir_left_next = dir_left_reg;
        result_next   = result_reg;
        zero_next     = zero_reg;
        illegal_next  = illegal_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (alu_is_shift && (shamt != '0)) begin
                        shift_next    = B;
                        count_next    = shamt;
                        dir_left_next = (ALUOperation == OP_SLL);
                        state_next    = ST_SHIFT;
                    end else begin
                        result_next  = alu_value;
                        zero_next    = (alu_value == '0);
                        illegal_next = alu_illegal;
                        state_next   = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                shift_next = shift_step;
                count_next = count_reg - 1'b1;
                // Last step: capture the shifted value directly so DONE follows edge k+shamt.
                if (count_reg == SHAMT_WIDTH'(1)) begin
                    result_next  = shift_step;
                    zero_next    = (shift_step == '0);
                    illegal_next = 1'b0;
                    state_next   = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg    <= '0;
            count_reg    <= '0;
            dir_left_reg <= 1'b0;
            result_reg   <= '0;
            zero_reg     <= 1'b0;
            illegal_reg  <= 1'b0;
        end else begin
            shift_reg    <= shift_next;
            count_reg    <= count_next;
            dir_left_reg <= dir_left_next;
            result_reg   <= result_next;
            zero_reg     <= zero_next;
            illegal_reg  <= illegal_next;
        end
    end

    assign ALUResult = result_reg;
    assign Zero      = zero_reg;
    assign Illegal   = illegal_reg;

`ifdef ALU_OVERFLOW_EN
    logic [DATA_WIDTH-1:0] sum_value;
    logic [DATA_WIDTH-1:0] diff_value;
    logic                  add_ovf;
    logic                  sub_ovf;
    logic                  ovf_reg, ovf_next;

    assign sum_value  = A + B;
    assign diff_value = A - B;
    assign add_ovf    = (A[DATA_WIDTH-1] == B[DATA_WIDTH-1]) &&
                        (sum_value[DATA_WIDTH-1] != A[DATA_WIDTH-1]);
    assign sub_ovf    = (A[DATA_WIDTH-1] != B[DATA_WIDTH-1]) &&
                        (diff_value[DATA_WIDTH-1] != A[DATA_WIDTH-1]);

    always_comb begin
        ovf_next = ovf_reg;
        if (accept) begin
            if (ALUOperation == OP_ADD) begin
                ovf_next = add_ovf;
            end else if (ALUOperation == OP_SUB) begin
                ovf_next = sub_ovf;
            end else begin
                ovf_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_reg <= 1'b0;
        end else begin
            ovf_reg <= ovf_next;
        end
    end

    assign Overflow = ovf_reg;
`else
    assign Overflow = 1'b0;
`endif

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Sequential execute stage directly downstream of the ALU control decoder.
- Consumes the 4-bit ALU operation code and the operands, then produces a registered result with Zero and illegal-op flags.
- Logical, arithmetic and LUI ops take a fixed 1 cycle.
- SLL/SRL run on an iterative 1-bit-per-cycle shifter, so latency varies with the shift amount; valid/ready handshakes sit on both sides.

Parameters:
- DATA_WIDTH, 32, operand/result width; must be even and ≥ 8.
- SHAMT_WIDTH, 5, shift-amount width; max shift = 2^SHAMT_WIDTH - 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operation and operands presented.
- in_ready  output  1  unit can accept; high only in IDLE.
- ALUOperation  input  4  op code: 0000 AND, 0001 OR, 0010 NOR, 0011 ADD, 0100 SUB, 0101 SLL, 0110 SRL, 0111 LUI; any other value is illegal.
- A  input  DATA_WIDTH  operand A (rs).
- B  input  DATA_WIDTH  operand B (rt/immediate); this is the shifted operand for SLL/SRL.
- shamt  input  SHAMT_WIDTH  shift amount.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- ALUResult  output  DATA_WIDTH  registered result.
- Zero  output  1  ALUResult == 0.
- Illegal  output  1  the op code was not one of the eight legal codes.
- Overflow  output  1  signed overflow; see Optional Feature.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
  - Reset puts the FSM in IDLE.
  - in_ready=1, out_valid=0, ALUResult=0, Zero=0, Illegal=0, Overflow=0.
  - Internal shift register and counter are cleared.
- FSM states: IDLE, SHIFT, DONE. in_ready = (state==IDLE). out_valid = (state==DONE).
- IDLE, on in_valid && in_ready at edge k:
  - Non-shift op, or shift with shamt==0: compute and register the result, go to DONE. out_valid is high in the cycle after edge k (latency 1).
  - SLL/SRL with shamt>0: load B into the shift register, count = shamt, go to SHIFT.
  - Operands and op are latched at acceptance. Input changes afterwards are ignored.
- SHIFT, every edge:
  - Shift 1 bit (SLL left, SRL logical right with 0 fill) and decrement count.
  - When count reaches 0, register the result and go to DONE.
  - out_valid rises after edge k+shamt. Example: shamt=31 gives 31 cycles.
- DONE:
  - Hold ALUResult, Zero, Illegal and Overflow stable while out_ready=0.
  - On out_ready=1, return to IDLE at that edge.
  - No bypass: a new op is accepted one cycle later at the earliest, giving a max throughput of one op per 2 cycles.
- Arithmetic rules, all results truncated to DATA_WIDTH:
  - AND: A&B. OR: A|B. NOR: ~(A|B).
  - ADD: A+B (wrap-around). SUB: A-B (wrap-around).
  - LUI: {B[DATA_WIDTH/2-1:0], DATA_WIDTH/2 zeros}.
- Illegal op code (e.g. 1001):
  - 1-cycle path; ALUResult=0, Illegal=1, Zero=1.
  - Does not hang the FSM.
- Zero is computed from the registered result and is valid whenever out_valid=1.
- Reset mid-operation (SHIFT or DONE): abort, discard the result, return to IDLE with reset values in the next cycle.
- in_valid while in SHIFT/DONE: not accepted, because in_ready=0. The upstream stage must hold its inputs.

Optional Feature:
- Macro ALU_OVERFLOW_EN.
- Defined:
  - Overflow = signed overflow of ADD/SUB. ADD sets it when A and B have the same sign and the result sign differs. SUB sets it when A and B have differing signs and the result sign differs from A.
  - Overflow is registered with the result; 0 for all other ops.
  - The result is still written (wrap-around).
- Undefined: Overflow is tied to 0 and no detection logic is built.

Test Plan:
- Reset, then ADD A=0x00000005 B=0x00000003, out_ready=1 -> out_valid one cycle after accept, ALUResult=0x00000008, Zero=0, then in_ready=1 the next cycle.
- SUB A=0x12345678 B=0x12345678 -> ALUResult=0, Zero=1. NOR A=0 B=0 -> 0xFFFFFFFF.
- SLL B=0x00000001 shamt=31 -> out_valid exactly 31 cycles after accept, ALUResult=0x80000000. SRL B=0x80000000 shamt=4 -> 0x08000000 after 4 cycles. SLL shamt=0 -> B unchanged, latency 1.
- LUI B=0x0000ABCD -> 0xABCD0000. Illegal op 1001 -> ALUResult=0, Illegal=1, Zero=1, latency 1.
- Backpressure: out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0; in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
- Reset asserted 3 cycles into a shamt=20 SLL -> next cycle IDLE, out_valid=0, ALUResult=0. With ALU_OVERFLOW_EN: ADD 0x7FFFFFFF+1 -> 0x80000000, Overflow=1.
